// File: rtl/reg_file_2r1w.sv
// Register file with one write port and two independent registered read ports.
// Optional hard-wired zero register and optional write-to-read bypass.
// Reads have one cycle of latency, and there is no combinational path from any
// input to the read data outputs.
//
// Handshake: there is no backpressure. A read issued with re_x=1 at edge N is
// presented on rdata_x after edge N, and that value holds until the next edge
// with re_x=1 or a reset.

module reg_file_2r1w #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re_a,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic             re_b,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b
);

    // One extra bit so that DEPTH itself is representable, even when DEPTH is a
    // power of two and every address is legal.
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_a_q;
    logic [WIDTH-1:0] rdata_b_q;

    logic             wr_en_d;
    logic [WIDTH-1:0] rdata_a_d;
    logic [WIDTH-1:0] rdata_b_d;

    // Selects the value one read port captures at the next edge, in priority
    // order: out of range, zero register, bypass, then stored contents.
    function automatic logic [WIDTH-1:0] read_sel(input logic [AW-1:0] addr);
        logic [WIDTH-1:0] val;
        val = '0;
        if ({1'b0, addr} >= DEPTH_W) begin
            val = '0;
        end else if ((ZERO_REG != 0) && (addr == '0)) begin
            val = '0;
        end else if ((BYPASS != 0) && we && (waddr == addr)) begin
            val = wdata;
        end else begin
            val = mem_q[addr];
        end
        return val;
    endfunction

    // Decode which write actually lands and what each read port would capture.
    always_comb begin
        wr_en_d = we && ({1'b0, waddr} < DEPTH_W) &&
                  !((ZERO_REG != 0) && (waddr == '0));
        rdata_a_d = read_sel(raddr_a);
        rdata_b_d = read_sel(raddr_b);
    end

    // Storage array: cleared on reset, otherwise updated by a qualified write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_d) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read data registers: capture on enable, hold otherwise, clear on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            if (re_a) begin
                rdata_a_q <= rdata_a_d;
            end
            if (re_b) begin
                rdata_b_q <= rdata_b_d;
            end
        end
    end

    assign rdata_a = rdata_a_q;
    assign rdata_b = rdata_b_q;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench for reg_file_2r1w. Two builds share one stimulus stream:
//   u_def : 32x32, zero register on, bypass on
//   u_alt : 24x32, zero register off, bypass off
// The driver pushes hand-computed expected read data into per-port queues; a
// monitor pops and compares one cycle after each tagged read.

module tb_reg_file_2r1w;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re_a;
  logic [4:0]  raddr_a;
  logic        re_b;
  logic [4:0]  raddr_b;
  logic [31:0] rdata_a_def, rdata_b_def, rdata_a_alt, rdata_b_alt;

  logic        pend;
  logic        pend_q;

  logic [31:0] exp_a_def_q[$];
  logic [31:0] exp_b_def_q[$];
  logic [31:0] exp_a_alt_q[$];
  logic [31:0] exp_b_alt_q[$];

  int checks = 0;
  int errors = 0;

  reg_file_2r1w #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1), .BYPASS(1)) u_def (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a_def),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b_def)
  );

  reg_file_2r1w #(.WIDTH(32), .DEPTH(24), .ZERO_REG(0), .BYPASS(0)) u_alt (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a_alt),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b_alt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) pend_q <= pend;

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pop_check(input string name, input logic [31:0] act, inout logic [31:0] q[$]);
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: expected queue empty, got 0x%08h", name, act);
    end else begin
      check(name, act, q.pop_front());
    end
  endtask

  // Monitor: outputs are valid one cycle after a tagged cycle's edge.
  always @(negedge clk) begin
    if (pend_q === 1'b1) begin
      pop_check("def_rdata_a", rdata_a_def, exp_a_def_q);
      pop_check("def_rdata_b", rdata_b_def, exp_b_def_q);
      pop_check("alt_rdata_a", rdata_a_alt, exp_a_alt_q);
      pop_check("alt_rdata_b", rdata_b_alt, exp_b_alt_q);
    end
  end

  // ---------------- driver ----------------
  task automatic cyc(input logic rst, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                     input logic rae, input logic [4:0] ra, input logic rbe, input logic [4:0] rb,
                     input logic chk, input logic [31:0] ea_d, input logic [31:0] eb_d,
                     input logic [31:0] ea_n, input logic [31:0] eb_n);
    @(negedge clk);
    #1;
    rst_n   = ~rst;
    we      = w;
    waddr   = wa;
    wdata   = wd;
    re_a    = rae;
    raddr_a = ra;
    re_b    = rbe;
    raddr_b = rb;
    pend    = chk;
    if (chk) begin
      exp_a_def_q.push_back(ea_d);
      exp_b_def_q.push_back(eb_d);
      exp_a_alt_q.push_back(ea_n);
      exp_b_alt_q.push_back(eb_n);
    end
  endtask

  // Known contents after the directed writes (step 13 sweep).
  function automatic logic [31:0] mem_def(input int i);
    case (i)
      5:       return 32'hDEADBEEF;
      7:       return 32'h22;
      9:       return 32'h99;
      30:      return 32'hAB;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] mem_alt(input int i);
    case (i)
      0:       return 32'hFFFFFFFF;
      5:       return 32'hDEADBEEF;
      7:       return 32'h22;
      9:       return 32'h99;
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    re_a = 1'b0; raddr_a = '0; re_b = 1'b0; raddr_b = '0; pend = 1'b0;
    repeat (2) @(posedge clk);

    // 1: reset edge ignores write and read enables
    cyc(1, 1, 5'd3, 32'h55, 1, 5'd3, 1, 5'd3, 1, 0, 0, 0, 0);
    // 2: first normal edge writes reg 5; outputs hold
    cyc(0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd3, 0, 5'd3, 1, 0, 0, 0, 0);
    // 3: read reg 5 on A, reg 3 (untouched) on B
    cyc(0, 0, 5'd0, 32'h0, 1, 5'd5, 1, 5'd3, 1, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0);
    // 4: hold with re=0
    cyc(0, 0, 5'd0, 32'h0, 0, 5'd1, 0, 5'd2, 1, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0);
    // 5: reg 7 = 0x11
    cyc(0, 1, 5'd7, 32'h11, 0, 5'd0, 0, 5'd0, 1, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0);
    // 6: same-edge write 0x22 and read of 7 on both ports
    cyc(0, 1, 5'd7, 32'h22, 1, 5'd7, 1, 5'd7, 1, 32'h22, 32'h22, 32'h11, 32'h11);
    // 7: next read sees 0x22 everywhere
    cyc(0, 0, 5'd0, 32'h0, 1, 5'd7, 1, 5'd7, 1, 32'h22, 32'h22, 32'h22, 32'h22);
    // 8: write all-ones to reg 0 with read of 0 on B
    cyc(0, 1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 1, 5'd0, 1, 32'h22, 0, 32'h22, 0);
    // 9: reg 0 stays zero on def, holds the write on alt
    cyc(0, 0, 5'd0, 32'h0, 1, 5'd0, 1, 5'd0, 1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    // 10: write to 30 (out of range on alt) with read of 30
    cyc(0, 1, 5'd30, 32'hAB, 1, 5'd30, 1, 5'd5, 1, 32'hAB, 32'hDEADBEEF, 0, 32'hDEADBEEF);
    // 11: re-read 30 and 7
    cyc(0, 0, 5'd0, 32'h0, 1, 5'd30, 1, 5'd7, 1, 32'hAB, 32'h22, 0, 32'h22);
    // 12: bypass only on the matching port
    cyc(0, 1, 5'd9, 32'h99, 1, 5'd9, 1, 5'd10, 1, 32'h99, 0, 0, 0);
    // 13: sweep all addresses
    for (int i = 0; i < 32; i += 2) begin
      cyc(0, 0, 5'd0, 32'h0, 1, 5'(i), 1, 5'(i + 1), 1,
          mem_def(i), mem_def(i + 1),
          (i < 24) ? mem_alt(i) : 32'h0, (i + 1 < 24) ? mem_alt(i + 1) : 32'h0);
    end
    // 14: fill every register with its index
    for (int i = 0; i < 32; i++) begin
      cyc(0, 1, 5'(i), 32'(i), 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0);
    end
    for (int i = 0; i < 32; i += 2) begin
      cyc(0, 0, 5'd0, 32'h0, 1, 5'(i), 1, 5'(i + 1), 1,
          (i == 0) ? 32'h0 : 32'(i), 32'(i + 1),
          (i < 24) ? 32'(i) : 32'h0, (i + 1 < 24) ? 32'(i + 1) : 32'h0);
    end
    // 15: one reset edge with enables active, then everything reads zero
    cyc(1, 1, 5'd4, 32'h1234, 1, 5'd4, 1, 5'd6, 1, 0, 0, 0, 0);
    for (int i = 0; i < 32; i += 2) begin
      cyc(0, 0, 5'd0, 32'h0, 1, 5'(i), 1, 5'(i + 1), 1, 0, 0, 0, 0);
    end

    cyc(0, 0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_a_def_q.size() + exp_b_def_q.size() + exp_a_alt_q.size() + exp_b_alt_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, expected 0",
               exp_a_def_q.size() + exp_b_def_q.size() + exp_a_alt_q.size() + exp_b_alt_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_2r1w.md
REG_FILE_2R1W -- requirements
Module: reg_file_2r1w

Interface
REQ-001 Parameter WIDTH, default 32: data width of every register, in bits.
REQ-002 Parameter DEPTH, default 32: number of registers; legal range 2..256.
REQ-003 Parameter ZERO_REG, default 1: when 1, register 0 always reads 0 and ignores writes.
REQ-004 Parameter BYPASS, default 1: when 1, a same-cycle write to a read address forwards write data to that read port.
REQ-005 Derived constant AW = $clog2(DEPTH) SHALL set the width of all address ports.
REQ-006 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-007 rst_n  input  1  reset, synchronous and active-low.
REQ-008 we  input  1  write enable.
REQ-009 waddr  input  AW  write address.
REQ-010 wdata  input  WIDTH  write data.
REQ-011 re_a  input  1  read enable, port A.
REQ-012 raddr_a  input  AW  read address, port A.
REQ-013 rdata_a  output  WIDTH  registered read data, port A.
REQ-014 re_b  input  1  read enable, port B.
REQ-015 raddr_b  input  AW  read address, port B.
REQ-016 rdata_b  output  WIDTH  registered read data, port B.

Function
REQ-017 Storage SHALL be DEPTH registers of WIDTH bits, with one write port and two independent read ports.
REQ-018 Write: if we=1 and waddr<DEPTH at a rising edge, then reg[waddr] SHALL become wdata at that edge.
REQ-019 If waddr>=DEPTH, the write SHALL be ignored and no register SHALL change.
REQ-020 If ZERO_REG=1 and waddr=0, the write SHALL be ignored.
REQ-021 Read latency SHALL be 1 cycle: if re_x=1 at edge N, rdata_x SHALL show the selected value after edge N.
REQ-022 If re_x=0 at an edge, rdata_x SHALL hold its previous value.
REQ-023 Read source priority, per port, highest first:
  (a) raddr_x>=DEPTH -> 0;
  (b) ZERO_REG=1 and raddr_x=0 -> 0;
  (c) BYPASS=1, we=1 and waddr=raddr_x -> wdata;
  (d) otherwise reg[raddr_x] as it was before the edge.
REQ-024 With BYPASS=0 and a same-edge write and read of one address, the read SHALL return the old contents; the new value SHALL be visible from the next read.
REQ-025 Ports A and B SHALL operate independently; equal addresses on both ports SHALL return identical data.
REQ-026 The block SHALL contain no combinational path from any input to rdata_a or rdata_b.
REQ-027 When ZERO_REG=1, bypass SHALL never forward to address 0.

Reset
REQ-028 When rst_n=0 at a rising edge, every storage register, rdata_a and rdata_b SHALL become 0.
REQ-029 During a reset edge, we, re_a and re_b SHALL be ignored.
REQ-030 The first edge with rst_n=1 SHALL operate normally, with no recovery cycle.
REQ-031 A reset asserted between a write and the following read SHALL make that read return 0.

Verification
REQ-032 Reset, then write 0xDEADBEEF to reg 5; next cycle set re_a=1, raddr_a=5 -> rdata_a=0xDEADBEEF one cycle later, and holds with re_a=0.
REQ-033 BYPASS=1, reg 7 = 0x11; same edge: we=1, waddr=7, wdata=0x22, re_a=re_b=1, raddr_a=raddr_b=7 -> both ports read 0x22.
  BYPASS=0 build, same stimulus -> both ports read 0x11, then 0x22 on the next read.
REQ-034 ZERO_REG=1: write 0xFFFFFFFF to reg 0 with re_b=1, raddr_b=0 on the same edge -> rdata_b=0 on that read and on all later reads.
REQ-035 DEPTH=24: write 0xAB to address 30 -> no register changes; reading address 30 -> 0; a full sweep of addresses 0..23 is unchanged.
REQ-036 Fill all registers with their index; pulse rst_n=0 for one edge -> every register, rdata_a and rdata_b read 0 afterwards.
REQ-037 Random stimulus of 10k cycles on both ports -> rdata matches a reference model each cycle, for WIDTH in {8, 32} and DEPTH in {2, 32}.
